// File: rtl/soc_sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID / uptime register block.
interface soc_sysid_regs_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/soc_sysid_regs.sv
// System ID, build timestamp, scratch/control registers and a 64-bit uptime
// counter with a coherent LO-then-HI read. Registered read, fixed latency 1.
module soc_sysid_regs #(
    parameter logic [31:0] ID            = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd0,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter logic        CNT_EN_RESET  = 1'b1
) (
    input logic              clock,
    input logic              reset_n,
    soc_sysid_regs_if.slave  bus
);
    localparam logic [31:0] CAPS = 32'h0000_0001;

    logic [31:0] scratch;
    logic        cnt_en;
    logic [63:0] counter;
    logic [31:0] shadow;
    logic [31:0] rd_mux;
    logic        rd_go;
    logic        wr_scratch;
    logic        wr_ctrl;
    logic        cnt_clr;

    // A write wins over a simultaneous read; the read is simply dropped.
    assign rd_go      = bus.read & ~bus.write;
    assign wr_scratch = bus.write && (bus.address == 3'd2);
    // CONTROL only has bits in byte 0, so lane 0 gates the whole write.
    assign wr_ctrl    = bus.write && (bus.address == 3'd3) && bus.byteenable[0];
    assign cnt_clr    = wr_ctrl & bus.writedata[1];

    // Scratch register, one byte lane per byteenable bit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RESET;
        end else if (wr_scratch) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i])
                    scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    // Counter enable bit; CNT_CLR is a pulse and is not stored.
    always_ff @(posedge clock) begin
        if (!reset_n)
            cnt_en <= CNT_EN_RESET;
        else if (wr_ctrl)
            cnt_en <= bus.writedata[0];
    end

    // Free-running uptime counter; clear beats increment, wrap is silent.
    always_ff @(posedge clock) begin
        if (!reset_n)
            counter <= 64'd0;
        else if (cnt_clr)
            counter <= 64'd0;
        else if (cnt_en)
            counter <= counter + 64'd1;
    end

    // Read mux over the pre-update register values.
    always_comb begin
        rd_mux = 32'd0;
        case (bus.address)
            3'd0:    rd_mux = ID;
            3'd1:    rd_mux = TIMESTAMP;
            3'd2:    rd_mux = scratch;
            3'd3:    rd_mux = {31'd0, cnt_en};
            3'd4:    rd_mux = counter[31:0];
            3'd5:    rd_mux = shadow;
            3'd6:    rd_mux = CAPS;
            default: rd_mux = 32'd0;
        endcase
    end

    // Shadow grabs the upper half in the same cycle the lower half is read,
    // so a later HI read is coherent even across a carry.
    always_ff @(posedge clock) begin
        if (!reset_n)
            shadow <= 32'd0;
        else if (rd_go && (bus.address == 3'd4))
            shadow <= counter[63:32];
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.readdata      <= 32'd0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= rd_go;
            if (rd_go)
                bus.readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_soc_sysid_regs.sv
// Randomized + directed bench for soc_sysid_regs against a register-map model.
module tb_soc_sysid_regs;
    localparam logic [31:0] P_ID  = 32'h547D_0F2C;
    localparam logic [31:0] P_TS  = 32'd1417485996;
    localparam logic [31:0] P_SR  = 32'hA5A5_0001;
    localparam logic        P_EN  = 1'b1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    soc_sysid_regs_if bus ();

    soc_sysid_regs #(
        .ID(P_ID), .TIMESTAMP(P_TS), .SCRATCH_RESET(P_SR), .CNT_EN_RESET(P_EN)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] m_scratch;
    logic        m_en;
    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic [31:0] m_rdata;
    logic        m_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [2:0] a);
        case (a)
            3'd0: return P_ID;
            3'd1: return P_TS;
            3'd2: return m_scratch;
            3'd3: return {31'd0, m_en};
            3'd4: return m_cnt[31:0];
            3'd5: return m_shadow;
            3'd6: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive, clock, update model, check outputs.
    task automatic step(input logic r, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic rn);
        logic [63:0] c_old;
        logic        en_old;
        logic        clr;
        bus.read = r; bus.write = w; bus.address = a;
        bus.writedata = d; bus.byteenable = be; reset_n = rn;
        @(posedge clock);
        if (!rn) begin
            m_vld = 1'b0; m_rdata = 32'd0; m_scratch = P_SR;
            m_en = P_EN; m_cnt = 64'd0; m_shadow = 32'd0;
        end else begin
            c_old  = m_cnt;
            en_old = m_en;
            clr    = 1'b0;
            m_vld  = r && !w;
            if (m_vld) begin
                m_rdata = reg_val(a);
                if (a == 3'd4) m_shadow = c_old[63:32];
            end
            if (w && a == 3'd2)
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
            if (w && a == 3'd3 && be[0]) begin
                m_en = d[0];
                clr  = d[1];
            end
            m_cnt = clr ? 64'd0 : (en_old ? c_old + 64'd1 : c_old);
        end
        #1;
        chk("readdatavalid", {31'd0, bus.readdatavalid}, {31'd0, m_vld});
        chk("readdata", bus.readdata, m_rdata);
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, a, d, be, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1);
    endtask

    initial begin
        bus.read = 0; bus.write = 0; bus.address = 0;
        bus.writedata = 0; bus.byteenable = 0;
        m_scratch = 0; m_en = 0; m_cnt = 0; m_shadow = 0; m_rdata = 0; m_vld = 0;

        // reset state
        step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);

        // back-to-back full map read
        for (int a = 0; a < 8; a++) rd(3'(a));
        idle(1);

        // byte-enabled scratch writes, RO write ignored
        wr(3'd2, 32'hDEAD_BEEF, 4'b1111);
        wr(3'd2, 32'h0000_0012, 4'b0001);
        rd(3'd2);
        chk("scratch_merge", bus.readdata, 32'hDEAD_BE12);
        wr(3'd0, 32'hFFFF_FFFF, 4'b1111);
        rd(3'd0);
        chk("id_ro", bus.readdata, P_ID);
        wr(3'd2, 32'h1234_5678, 4'b0000);
        rd(3'd2);

        // coherent LO/HI across a carry
        idle(1);
        force dut.counter = 64'h0000_0001_FFFF_FFFF;
        m_cnt = 64'h0000_0001_FFFF_FFFF;
        rd(3'd4);
        release dut.counter;
        chk("wrap_lo", bus.readdata, 32'hFFFF_FFFF);
        idle(2);
        rd(3'd5);
        chk("wrap_hi", bus.readdata, 32'h0000_0001);
        wr(3'd3, 32'd3, 4'b0001);   // clear resyncs model and DUT counter
        rd(3'd4);

        // disable, then clear+enable
        wr(3'd3, 32'd0, 4'b0001);
        rd(3'd4);
        idle(10);
        rd(3'd4);
        wr(3'd3, 32'd3, 4'b0001);
        rd(3'd4);
        chk("clr_n1", bus.readdata, 32'd0);
        rd(3'd4);
        chk("clr_n2", bus.readdata, 32'd1);

        // reset while a read is in flight
        wr(3'd2, 32'hCAFE_F00D, 4'b1111);
        rd(3'd2);
        step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
        chk("rst_vld", {31'd0, bus.readdatavalid}, 32'd0);
        rd(3'd2);
        chk("rst_scratch", bus.readdata, P_SR);
        rd(3'd4);

        // simultaneous read and write
        step(1'b1, 1'b1, 3'd2, 32'h0BAD_F00D, 4'b1111, 1'b1);
        rd(3'd2);
        chk("rw_scratch", bus.readdata, 32'h0BAD_F00D);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int          kind;
            logic [2:0]  a;
            logic [31:0] d;
            logic [3:0]  be;
            kind = $urandom_range(0, 99);
            a    = 3'($urandom_range(0, 7));
            d    = $urandom;
            be   = 4'($urandom_range(0, 15));
            if (kind < 2)       step(1'b0, 1'b0, a, d, be, 1'b0);
            else if (kind < 45) rd(a);
            else if (kind < 70) wr(a, d, be);
            else if (kind < 74) step(1'b1, 1'b1, a, d, be, 1'b1);
            else                idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
